// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler: walks an MxNxK tile loop for one job, issuing per-tile
// A/B/C addresses plus a start pulse to the systolic engine and waiting for its done.
module matmul_tile_scheduler #(
  parameter int TILE_A_BYTES = 32,
  parameter int TILE_B_BYTES = 32,
  parameter int TILE_C_BYTES = 64,
  parameter int DIM_W        = 8,
  parameter int TIMEOUT      = 4096
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_aresetn,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [63:0]        job_base_a,
  input  logic [63:0]        job_base_b,
  input  logic [63:0]        job_base_c,
  input  logic [DIM_W-1:0]   job_tiles_m,
  input  logic [DIM_W-1:0]   job_tiles_n,
  input  logic [DIM_W-1:0]   job_tiles_k,
  input  logic               abort,
  output logic [63:0]        eng_addr_a,
  output logic [63:0]        eng_addr_b,
  output logic [63:0]        eng_addr_c,
  output logic               eng_start,
  input  logic               eng_done,
  output logic               busy,
  output logic               job_done,
  output logic               err_zero,
  output logic               err_timeout,
  output logic               aborted,
  output logic [3*DIM_W-1:0] tiles_issued
);
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, ADVANCE = 3'd3, DRAIN = 3'd4, FINISH = 3'd5;
  localparam int WD_W = $clog2(TIMEOUT);
  logic [2:0] state;
  logic live;
  logic [DIM_W-1:0] dim_m, dim_n, dim_k, i, j, k;
  logic [63:0] ptr_a, ptr_b, ptr_c, row_a, col_b, base_b, stride_a, stride_b;
  logic [WD_W-1:0] wd;
  logic f_zero, f_timeout, f_abort;
  logic zero_dim, expire, k_end, j_end, i_end, draining;
  assign zero_dim = job_tiles_m == '0 || job_tiles_n == '0 || job_tiles_k == '0;
  assign expire = wd == WD_W'(TIMEOUT - 1);
  assign k_end = k == dim_k - 1'b1;
  assign j_end = j == dim_n - 1'b1;
  assign i_end = i == dim_m - 1'b1;
  assign draining = state == DRAIN || abort;
  // live keeps job_ready low while reset is held and for the release cycle
  assign job_ready = live && state == IDLE;
  assign busy = state != IDLE;
  assign eng_start = state == ISSUE;
  assign job_done = state == FINISH;
  assign err_zero = job_done && f_zero;
  assign err_timeout = job_done && f_timeout;
  assign aborted = job_done && f_abort;
  assign eng_addr_a = ptr_a;
  assign eng_addr_b = ptr_b;
  assign eng_addr_c = ptr_c;
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      state <= IDLE;
      live <= 1'b0;
      {dim_m, dim_n, dim_k, i, j, k} <= '0;
      {ptr_a, ptr_b, ptr_c, row_a, col_b, base_b, stride_a, stride_b} <= '0;
      wd <= '0;
      {f_zero, f_timeout, f_abort} <= '0;
      tiles_issued <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: if (job_valid && job_ready) begin
          dim_m <= job_tiles_m;
          dim_n <= job_tiles_n;
          dim_k <= job_tiles_k;
          {i, j, k} <= '0;
          ptr_a <= job_base_a;
          row_a <= job_base_a;
          ptr_b <= job_base_b;
          col_b <= job_base_b;
          base_b <= job_base_b;
          ptr_c <= job_base_c;
          stride_a <= 64'(job_tiles_k) * 64'(TILE_A_BYTES);
          stride_b <= 64'(job_tiles_n) * 64'(TILE_B_BYTES);
          tiles_issued <= '0;
          f_zero <= zero_dim;
          f_timeout <= 1'b0;
          f_abort <= 1'b0;
          state <= zero_dim ? FINISH : ISSUE;
        end
        ISSUE: begin
          tiles_issued <= tiles_issued + 1'b1;
          wd <= '0;
          state <= abort ? DRAIN : WAIT;
        end
        WAIT, DRAIN: if (eng_done) begin
          f_abort <= draining;
          state <= draining ? FINISH : ADVANCE;
        end else if (expire) begin
          f_timeout <= 1'b1;
          state <= FINISH;
        end else
          wd <= wd + 1'b1;
        ADVANCE: begin
          ptr_c <= ptr_c + 64'(TILE_C_BYTES);
          wd <= '0;
          if (!k_end) begin
            k <= k + 1'b1;
            ptr_a <= ptr_a + 64'(TILE_A_BYTES);
            ptr_b <= ptr_b + stride_b;
          end else begin
            k <= '0;
            if (!j_end) begin
              j <= j + 1'b1;
              col_b <= col_b + 64'(TILE_B_BYTES);
              ptr_b <= col_b + 64'(TILE_B_BYTES);
              ptr_a <= row_a;
            end else if (!i_end) begin
              j <= '0;
              i <= i + 1'b1;
              row_a <= row_a + stride_a;
              ptr_a <= row_a + stride_a;
              col_b <= base_b;
              ptr_b <= base_b;
            end
          end
          state <= (k_end && j_end && i_end) ? FINISH : abort ? DRAIN : ISSUE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// tb_matmul_tile_scheduler: drives jobs with a cycle-accurate engine model and checks
// addresses, timing and status against closed-form tile-index arithmetic.
module tb_matmul_tile_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  logic job_valid, job_ready, abort, eng_start, eng_done, busy, job_done;
  logic err_zero, err_timeout, aborted;
  logic [63:0] base_a, base_b, base_c, eng_addr_a, eng_addr_b, eng_addr_c;
  logic [7:0] tiles_m, tiles_n, tiles_k;
  logic [23:0] tiles_issued;
  int total = 0;
  int bad = 0;

  matmul_tile_scheduler #(.TIMEOUT(16)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_base_a(base_a), .job_base_b(base_b), .job_base_c(base_c),
    .job_tiles_m(tiles_m), .job_tiles_n(tiles_n), .job_tiles_k(tiles_k), .abort(abort),
    .eng_addr_a(eng_addr_a), .eng_addr_b(eng_addr_b), .eng_addr_c(eng_addr_c),
    .eng_start(eng_start), .eng_done(eng_done), .busy(busy), .job_done(job_done),
    .err_zero(err_zero), .err_timeout(err_timeout), .aborted(aborted), .tiles_issued(tiles_issued)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 normal, 1 abort raised in WAIT of stop, 2 abort raised in ISSUE of stop, 3 engine hangs on stop
  task automatic run_job(input int m, input int n, input int kk, input logic [63:0] ba,
                         input logic [63:0] bb, input logic [63:0] bc, input int stop,
                         input int mode, input int fix_lat);
    int tiles, ti, tj, tk, lat, guard;
    logic [63:0] ea, eb, ec;
    guard = 0;
    while (!job_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("ready_before", 64'(job_ready), 64'd1);
    job_valid = 1'b1;
    tiles_m = 8'(m);
    tiles_n = 8'(n);
    tiles_k = 8'(kk);
    base_a = ba;
    base_b = bb;
    base_c = bc;
    tick();
    job_valid = 1'b0;
    tiles = m * n * kk;
    if (tiles == 0) begin
      chk("zero_flags", 64'({eng_start, job_done, err_zero, err_timeout, aborted}), 64'b01100);
      chk("zero_cnt", 64'(tiles_issued), 64'd0);
      tick();
      chk("zero_ready", 64'(job_ready), 64'd1);
      return;
    end
    for (int t = 0; t < tiles; t++) begin
      ti = t / (n * kk);
      tj = (t / kk) % n;
      tk = t % kk;
      ea = ba + 64'(ti * kk + tk) * 64'd32;
      eb = bb + 64'(tk * n + tj) * 64'd32;
      ec = bc + 64'((ti * n + tj) * kk + tk) * 64'd64;
      chk("start", 64'(eng_start), 64'd1);
      chk("addr_a", eng_addr_a, ea);
      chk("addr_b", eng_addr_b, eb);
      chk("addr_c", eng_addr_c, ec);
      chk("cnt_issue", 64'(tiles_issued), 64'(t));
      if (mode == 2 && t == stop) abort = 1'b1;
      else eng_done = $urandom_range(0, 3) == 0;
      tick();
      eng_done = 1'b0;
      if (mode == 3 && t == stop) begin
        repeat (15) @(posedge clk);
        #1;
        chk("hang_pending", 64'({job_done, eng_start}), 64'd0);
        tick();
        chk("hang_flags", 64'({job_done, err_zero, err_timeout, aborted}), 64'b1010);
        chk("hang_cnt", 64'(tiles_issued), 64'(t + 1));
        tick();
        chk("hang_ready", 64'(job_ready), 64'd1);
        return;
      end
      if (mode == 1 && t == stop) abort = 1'b1;
      lat = fix_lat > 0 ? fix_lat : $urandom_range(1, 16);
      repeat (lat - 1) tick();
      chk("wait_hold", {eng_addr_a ^ ea, 7'b0, eng_start, 7'b0, job_done, 48'b0}, 64'd0);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      if (abort) begin
        chk("abort_flags", 64'({job_done, err_zero, err_timeout, aborted}), 64'b1001);
        chk("abort_cnt", 64'(tiles_issued), 64'(t + 1));
        abort = 1'b0;
        tick();
        chk("abort_ready", 64'(job_ready), 64'd1);
        return;
      end
      chk("advance", 64'({eng_start, job_done, busy}), 64'b001);
      eng_done = $urandom_range(0, 3) == 0;
      tick();
      eng_done = 1'b0;
    end
    chk("done_flags", 64'({job_done, err_zero, err_timeout, aborted}), 64'b1000);
    chk("done_cnt", 64'(tiles_issued), 64'(tiles));
    tick();
    chk("done_ready", 64'({job_ready, busy}), 64'b10);
  endtask

  initial begin
    rst_n = 1'b0;
    {job_valid, abort, eng_done} = '0;
    {base_a, base_b, base_c} = '0;
    {tiles_m, tiles_n, tiles_k} = '0;
    #12;
    chk("rst_ctl", 64'({job_ready, busy, eng_start, job_done, err_zero, err_timeout, aborted}), 64'd0);
    chk("rst_addr", eng_addr_a | eng_addr_b | eng_addr_c | 64'(tiles_issued), 64'd0);
    #11 rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(job_ready), 64'd1);
    run_job(1, 1, 1, 64'h1000, 64'h2000, 64'h3000, 0, 0, 10);
    run_job(2, 2, 2, 64'h0, 64'h0, 64'h0, 0, 0, 0);
    run_job(1, 0, 1, 64'h40, 64'h80, 64'hC0, 0, 0, 0);
    run_job(0, 3, 2, 64'h40, 64'h80, 64'hC0, 0, 0, 0);
    run_job(2, 1, 1, 64'h500, 64'h600, 64'h700, 0, 3, 0);
    run_job(1, 2, 1, 64'h100, 64'h200, 64'h300, 0, 0, 16);
    run_job(2, 2, 2, 64'h0, 64'h0, 64'h0, 2, 1, 5);
    run_job(2, 3, 2, 64'h10, 64'h20, 64'h30, 3, 2, 0);
    run_job(2, 2, 3, 64'hFFFF_FFFF_FFFF_FFC0, 64'hFFFF_FFFF_FFFF_FFE0, 64'hFFFF_FFFF_FFFF_FF00, 0, 0, 0);
    // asynchronous reset in the middle of a tile's WAIT
    while (!job_ready) tick();
    job_valid = 1'b1;
    {tiles_m, tiles_n, tiles_k} = {8'd1, 8'd1, 8'd2};
    {base_a, base_b, base_c} = {64'h1111, 64'h2222, 64'h3333};
    tick();
    job_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", 64'({job_ready, busy, eng_start, job_done}), 64'd0);
    chk("arst_addr", eng_addr_a | eng_addr_b | eng_addr_c | 64'(tiles_issued), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("stale_done", 64'({job_ready, busy, job_done}), 64'b100);
    run_job(1, 2, 2, 64'h4000, 64'h5000, 64'h6000, 0, 0, 0);
    for (int r = 0; r < 25; r++) begin
      int m, n, kk, md;
      m = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 3);
      n = $urandom_range(1, 3);
      kk = $urandom_range(1, 3);
      md = $urandom_range(0, 5) > 3 ? $urandom_range(1, 3) : 0;
      run_job(m, n, kk, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              m * n * kk > 0 ? $urandom_range(0, m * n * kk - 1) : 0, md, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
